// File: rtl/minisrc_bus_pkg.sv
// Shared definitions for the Mini-SRC internal bus sequencer.
// Contents: bus code map, opcode encodings, FSM state encoding and a helper
// that tells whether a bus code names a loadable register.
package minisrc_bus_pkg;

    localparam int unsigned NUM_BUS_SEL = 24;
    localparam int unsigned CODE_W      = 5;
    localparam int unsigned OP_W        = 2;
    localparam int unsigned STEP_W      = 2;
    localparam int unsigned STATE_W     = 2;

    // Source/destination codes; the code is also the bit index in both select vectors.
    localparam logic [CODE_W-1:0] CODE_R0     = 5'd0;
    localparam logic [CODE_W-1:0] CODE_R1     = 5'd1;
    localparam logic [CODE_W-1:0] CODE_R2     = 5'd2;
    localparam logic [CODE_W-1:0] CODE_R3     = 5'd3;
    localparam logic [CODE_W-1:0] CODE_R4     = 5'd4;
    localparam logic [CODE_W-1:0] CODE_R5     = 5'd5;
    localparam logic [CODE_W-1:0] CODE_R6     = 5'd6;
    localparam logic [CODE_W-1:0] CODE_R7     = 5'd7;
    localparam logic [CODE_W-1:0] CODE_R8     = 5'd8;
    localparam logic [CODE_W-1:0] CODE_R9     = 5'd9;
    localparam logic [CODE_W-1:0] CODE_R10    = 5'd10;
    localparam logic [CODE_W-1:0] CODE_R11    = 5'd11;
    localparam logic [CODE_W-1:0] CODE_R12    = 5'd12;
    localparam logic [CODE_W-1:0] CODE_R13    = 5'd13;
    localparam logic [CODE_W-1:0] CODE_R14    = 5'd14;
    localparam logic [CODE_W-1:0] CODE_R15    = 5'd15;
    localparam logic [CODE_W-1:0] CODE_HI     = 5'd16;
    localparam logic [CODE_W-1:0] CODE_LO     = 5'd17;
    localparam logic [CODE_W-1:0] CODE_ZHIGH  = 5'd18;
    localparam logic [CODE_W-1:0] CODE_ZLOW   = 5'd19;
    localparam logic [CODE_W-1:0] CODE_PC     = 5'd20;
    localparam logic [CODE_W-1:0] CODE_MDR    = 5'd21;
    localparam logic [CODE_W-1:0] CODE_INPORT = 5'd22;
    localparam logic [CODE_W-1:0] CODE_C      = 5'd23;

    localparam logic [OP_W-1:0] OP_MOVE  = 2'b00;
    localparam logic [OP_W-1:0] OP_SWAP  = 2'b01;
    localparam logic [OP_W-1:0] OP_LOADC = 2'b10;
    localparam logic [OP_W-1:0] OP_RSVD  = 2'b11;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_SETTLE = 2'd1;
    localparam logic [STATE_W-1:0] ST_XFER   = 2'd2;

    // Codes that have a load enable: R0-R15, HI, LO, PC, MDR.
    function automatic logic is_reg_target(input logic [CODE_W-1:0] code);
        return (code <= CODE_LO) || (code == CODE_PC) || (code == CODE_MDR);
    endfunction

endpackage

// File: rtl/bus_sel_decoder.sv
// Decodes a 5-bit bus code into a one-hot select vector.
// Ports:
//   code  in  5   bus code (bit index of the select to raise)
//   en    in  1   when low the vector is all-zero
//   sel_c out 24  one-hot select, all-zero for codes above 23
module bus_sel_decoder
    import minisrc_bus_pkg::*;
(
    input  logic [CODE_W-1:0]      code,
    input  logic                   en,
    output logic [NUM_BUS_SEL-1:0] sel_c
);

    // Comparing against every index keeps out-of-range codes all-zero.
    always_comb begin
        sel_c = '0;
        for (int unsigned i = 0; i < NUM_BUS_SEL; i++) begin
            sel_c[i] = en && (code == CODE_W'(i));
        end
    end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Initiator side of the Mini-SRC internal bus: accepts MOVE/SWAP/LOADC
// requests and sequences one-hot source selects and register load enables.
// Ports:
//   clock, clear          clock and synchronous active-high reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_op/src/dst        operation and bus codes, latched at accept
//   bus_out_sel           one-hot bus source select
//   reg_in_sel            one-hot register load enable
//   busy                  inverse of req_ready
//   done / err            one-cycle completion / rejection pulses
module bus_transfer_sequencer
    import minisrc_bus_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 0,
    parameter int unsigned SCRATCH_REG   = 15
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [OP_W-1:0]        req_op,
    input  logic [CODE_W-1:0]      req_src,
    input  logic [CODE_W-1:0]      req_dst,
    output logic [NUM_BUS_SEL-1:0] bus_out_sel,
    output logic [NUM_BUS_SEL-1:0] reg_in_sel,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned        CNT_W          = 3;
    localparam logic [CNT_W-1:0]   SETTLE_LAST    = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic               HAS_SETTLE     = (SETTLE_CYCLES != 0);
    localparam logic [CODE_W-1:0]  SCRATCH_CODE   = CODE_W'(SCRATCH_REG);
    localparam logic [STEP_W-1:0]  SWAP_LAST_STEP = STEP_W'(2);
    localparam logic [STATE_W-1:0] ST_FIRST       = HAS_SETTLE ? ST_SETTLE : ST_XFER;

    logic [STATE_W-1:0]     state_q, state_d;
    logic [STEP_W-1:0]      step_q, step_d;
    logic [CNT_W-1:0]       settle_cnt_q, settle_cnt_d;
    logic [OP_W-1:0]        op_q, op_d;
    logic [CODE_W-1:0]      src_q, src_d;
    logic [CODE_W-1:0]      dst_q, dst_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic [NUM_BUS_SEL-1:0] bus_sel_q, bus_sel_d;
    logic [NUM_BUS_SEL-1:0] reg_sel_q, reg_sel_d;

    logic                   req_illegal_c;
    logic [STEP_W-1:0]      last_step_c;
    logic [CODE_W-1:0]      src_code_c, dst_code_c;
    logic                   bus_en_c, reg_en_c;

    // Request validation, evaluated on the accept edge.
    always_comb begin
        req_illegal_c = 1'b0;
        if (req_op == OP_RSVD) begin
            req_illegal_c = 1'b1;
        end
        if ((req_op != OP_LOADC) && (req_src > CODE_C)) begin
            req_illegal_c = 1'b1;
        end
        if (!is_reg_target(req_dst)) begin
            req_illegal_c = 1'b1;
        end
        if ((req_op == OP_SWAP) &&
            (!is_reg_target(req_src) || (req_src == SCRATCH_CODE) || (req_dst == SCRATCH_CODE))) begin
            req_illegal_c = 1'b1;
        end
    end

    assign last_step_c = (op_q == OP_SWAP) ? SWAP_LAST_STEP : '0;

    // Next-state logic for the sequencer FSM and its counters.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        settle_cnt_d = settle_cnt_q;
        op_d         = op_q;
        src_d        = src_q;
        dst_d        = dst_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_illegal_c) begin
                        err_d = 1'b1;
                    end else begin
                        op_d         = req_op;
                        src_d        = req_src;
                        dst_d        = req_dst;
                        step_d       = '0;
                        settle_cnt_d = '0;
                        state_d      = ST_FIRST;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_XFER;
                end else begin
                    settle_cnt_d = settle_cnt_q + CNT_W'(1);
                end
            end
            ST_XFER: begin
                if (step_q == last_step_c) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    step_d       = step_q + STEP_W'(1);
                    settle_cnt_d = '0;
                    state_d      = ST_FIRST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus codes for the step that will be active next cycle; SWAP rotates through the scratch.
    always_comb begin
        src_code_c = src_d;
        dst_code_c = dst_d;
        if (op_d == OP_LOADC) begin
            src_code_c = CODE_C;
        end else if (op_d == OP_SWAP) begin
            case (step_d)
                2'd0: begin
                    dst_code_c = SCRATCH_CODE;
                end
                2'd1: begin
                    src_code_c = dst_d;
                    dst_code_c = src_d;
                end
                default: begin
                    src_code_c = SCRATCH_CODE;
                end
            endcase
        end
    end

    assign bus_en_c = (state_d == ST_SETTLE) || (state_d == ST_XFER);
    assign reg_en_c = (state_d == ST_XFER);
    assign ready_d  = (state_d == ST_IDLE);
    assign busy_d   = ~ready_d;

    bus_sel_decoder u_bus_dec (
        .code  (src_code_c),
        .en    (bus_en_c),
        .sel_c (bus_sel_d)
    );

    bus_sel_decoder u_reg_dec (
        .code  (dst_code_c),
        .en    (reg_en_c),
        .sel_c (reg_sel_d)
    );

    // State and output registers.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            settle_cnt_q <= '0;
            op_q         <= OP_MOVE;
            src_q        <= '0;
            dst_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            bus_sel_q    <= '0;
            reg_sel_q    <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            settle_cnt_q <= settle_cnt_d;
            op_q         <= op_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            bus_sel_q    <= bus_sel_d;
            reg_sel_q    <= reg_sel_d;
        end
    end

    assign req_ready   = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign bus_out_sel = bus_sel_q;
    assign reg_in_sel  = reg_sel_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Bench for bus_transfer_sequencer: a bus-driven register file around a
// SETTLE_CYCLES=0 instance, plus a SETTLE_CYCLES=2 instance for timing.
module tb_bus_transfer_sequencer;
    import minisrc_bus_pkg::*;

    localparam int SCR = 15;
    localparam logic [31:0] ZH_VAL  = 32'h0000_1818;
    localparam logic [31:0] ZL_VAL  = 32'h1919_0000;
    localparam logic [31:0] INP_VAL = 32'h2222_2222;
    localparam logic [23:0] NO_LOAD = 24'hCC0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear;
    logic        req_valid, req_ready, busy, done, err;
    logic [1:0]  req_op;
    logic [4:0]  req_src, req_dst;
    logic [23:0] bus_out_sel, reg_in_sel;

    logic        req2_valid, req2_ready, busy2, done2, err2;
    logic [1:0]  req2_op;
    logic [4:0]  req2_src, req2_dst;
    logic [23:0] bus_out_sel2, reg_in_sel2;

    bus_transfer_sequencer #(.SETTLE_CYCLES(0), .SCRATCH_REG(15)) dut0 (
        .clock(clk), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_src(req_src), .req_dst(req_dst),
        .bus_out_sel(bus_out_sel), .reg_in_sel(reg_in_sel),
        .busy(busy), .done(done), .err(err));

    bus_transfer_sequencer #(.SETTLE_CYCLES(2), .SCRATCH_REG(15)) dut2 (
        .clock(clk), .clear(clear), .req_valid(req2_valid), .req_ready(req2_ready),
        .req_op(req2_op), .req_src(req2_src), .req_dst(req2_dst),
        .bus_out_sel(bus_out_sel2), .reg_in_sel(reg_in_sel2),
        .busy(busy2), .done(done2), .err(err2));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus and register file steered only by the DUT selects.
    logic [31:0] rf [NUM_BUS_SEL];
    logic [31:0] c_val;
    logic [31:0] bus;
    logic        poke_en;
    logic [4:0]  poke_idx;
    logic [31:0] poke_val;

    always_comb begin
        bus = '0;
        for (int i = 0; i < 24; i++) begin
            if (bus_out_sel[i]) begin
                bus = (i == 23) ? c_val : (i == 18) ? ZH_VAL : (i == 19) ? ZL_VAL :
                      (i == 22) ? INP_VAL : rf[i];
            end
        end
    end

    always @(posedge clk) begin
        if (poke_en) rf[poke_idx] <= poke_val;
        for (int i = 0; i < 24; i++) begin
            if (reg_in_sel[i]) rf[i] <= bus;
        end
    end

    // Select-vector invariants watched every cycle.
    logic mon_en = 1'b0;
    int   viol   = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if ($countones(bus_out_sel) > 1 || $countones(reg_in_sel) > 1 ||
                $countones(bus_out_sel2) > 1 || $countones(reg_in_sel2) > 1) viol++;
            if ((reg_in_sel & NO_LOAD) != 0 || (reg_in_sel2 & NO_LOAD) != 0) viol++;
            if ((reg_in_sel != 0 && bus_out_sel == 0) || (reg_in_sel2 != 0 && bus_out_sel2 == 0)) viol++;
            if (busy !== ~req_ready || busy2 !== ~req2_ready) viol++;
        end
    end

    // Reference model: architectural register contents after each request.
    logic [31:0] rf_exp [NUM_BUS_SEL];

    function automatic logic is_tgt(input int c);
        return (c <= 17) || (c == 20) || (c == 21);
    endfunction

    function automatic logic model_legal(input int op, input int src, input int dst);
        if (op == 3) return 1'b0;
        if (op != 2 && src > 23) return 1'b0;
        if (!is_tgt(dst)) return 1'b0;
        if (op == 1 && (!is_tgt(src) || src == SCR || dst == SCR)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_src(input int code);
        case (code)
            18: return ZH_VAL;
            19: return ZL_VAL;
            22: return INP_VAL;
            23: return c_val;
            default: return rf_exp[code];
        endcase
    endfunction

    task automatic apply_model(input logic [1:0] op, input int src, input int dst);
        logic [31:0] t;
        if (op == OP_MOVE) rf_exp[dst] = model_src(src);
        else if (op == OP_LOADC) rf_exp[dst] = c_val;
        else if (op == OP_SWAP) begin
            t = rf_exp[src];
            rf_exp[SCR] = t;
            rf_exp[src] = rf_exp[dst];
            rf_exp[dst] = t;
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = 5'(idx); poke_val = v;
        @(posedge clk);
        #1 poke_en = 1'b0;
        rf_exp[idx] = v;
    endtask

    task automatic check_rf(input string tag);
        int bad;
        bad = 0;
        for (int i = 23; i >= 0; i--) begin
            if (is_tgt(i) && rf[i] !== rf_exp[i]) bad = i;
        end
        chk($sformatf("%s/rf[%0d]", tag, bad), 64'(rf[bad]), 64'(rf_exp[bad]));
    endtask

    // Observation of one request on dut0 over a fixed window.
    int          r_done, r_ndone, r_err, r_nerr, r_xfer, r_bus, r_busy, r_first, r_last;
    logic [23:0] r_fbus, r_freg;

    task automatic run_txn(input string tag, input logic [1:0] op, input logic [4:0] src, input logic [4:0] dst);
        @(negedge clk);
        chk($sformatf("%s/ready_before", tag), 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = op; req_src = src; req_dst = dst;
        @(posedge clk);
        #1 req_valid = 1'b0;
        r_done = 0; r_ndone = 0; r_err = 0; r_nerr = 0; r_xfer = 0; r_bus = 0; r_busy = 0;
        r_first = 0; r_last = 0; r_fbus = '0; r_freg = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin r_ndone++; if (r_done == 0) r_done = c; end
            if (err === 1'b1) begin r_nerr++; if (r_err == 0) r_err = c; end
            if (reg_in_sel != 0) begin
                if (r_xfer == 0) begin r_first = c; r_fbus = bus_out_sel; r_freg = reg_in_sel; end
                r_last = c;
                r_xfer++;
            end
            if (bus_out_sel != 0) r_bus++;
            if (busy === 1'b1) r_busy++;
        end
    endtask

    task automatic check_txn(input string tag, input logic [1:0] op, input logic [4:0] src,
                             input logic [4:0] dst, input logic exp_err, input int exp_lat);
        int steps, fs, fd;
        steps = exp_err ? 0 : ((op == OP_SWAP) ? 3 : 1);
        chk($sformatf("%s/err_cycle", tag),   64'(r_err),   exp_err ? 64'd1 : 64'd0);
        chk($sformatf("%s/err_pulses", tag),  64'(r_nerr),  exp_err ? 64'd1 : 64'd0);
        chk($sformatf("%s/done_cycle", tag),  64'(r_done),  exp_err ? 64'd0 : 64'(exp_lat));
        chk($sformatf("%s/done_pulses", tag), 64'(r_ndone), exp_err ? 64'd0 : 64'd1);
        chk($sformatf("%s/xfer_cycles", tag), 64'(r_xfer),  64'(steps));
        chk($sformatf("%s/bus_cycles", tag),  64'(r_bus),   64'(steps));
        chk($sformatf("%s/busy_cycles", tag), 64'(r_busy),  64'(steps));
        if (!exp_err) begin
            fs = (op == OP_LOADC) ? 23 : int'(src);
            fd = (op == OP_SWAP) ? SCR : int'(dst);
            chk($sformatf("%s/xfer_contig", tag), 64'(r_last - r_first + 1), 64'(steps));
            chk($sformatf("%s/first_bus", tag), 64'(r_fbus), 64'(24'(1) << fs));
            chk($sformatf("%s/first_reg", tag), 64'(r_freg), 64'(24'(1) << fd));
            apply_model(op, int'(src), int'(dst));
        end
        check_rf(tag);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  src;
        logic [4:0]  dst;
        logic        pre_en;
        logic [4:0]  pre_idx;
        logic [31:0] pre_val;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [31:0] old2, old3;
        int          nd;
        int          rop, rsrc, rdst;
        logic        lg;

        vecs[0]  = '{OP_LOADC, 5'd0,  5'd0,  1'b0, 5'd0, 32'h0,        1'b0, 2};
        vecs[1]  = '{OP_MOVE,  5'd0,  5'd1,  1'b0, 5'd0, 32'h0,        1'b0, 2};
        vecs[2]  = '{OP_SWAP,  5'd0,  5'd1,  1'b1, 5'd1, 32'h12345678, 1'b0, 4};
        vecs[3]  = '{OP_RSVD,  5'd1,  5'd2,  1'b0, 5'd0, 32'h0,        1'b1, 0};
        vecs[4]  = '{OP_MOVE,  5'd0,  5'd19, 1'b0, 5'd0, 32'h0,        1'b1, 0};
        vecs[5]  = '{OP_SWAP,  5'd15, 5'd1,  1'b0, 5'd0, 32'h0,        1'b1, 0};
        vecs[6]  = '{OP_SWAP,  5'd1,  5'd15, 1'b0, 5'd0, 32'h0,        1'b1, 0};
        vecs[7]  = '{OP_MOVE,  5'd24, 5'd1,  1'b0, 5'd0, 32'h0,        1'b1, 0};
        vecs[8]  = '{OP_MOVE,  5'd5,  5'd5,  1'b0, 5'd0, 32'h0,        1'b0, 2};
        vecs[9]  = '{OP_MOVE,  5'd18, 5'd16, 1'b0, 5'd0, 32'h0,        1'b0, 2};
        vecs[10] = '{OP_LOADC, 5'd7,  5'd21, 1'b0, 5'd0, 32'h0,        1'b0, 2};
        vecs[11] = '{OP_SWAP,  5'd20, 5'd21, 1'b0, 5'd0, 32'h0,        1'b0, 4};
        vecs[12] = '{OP_SWAP,  5'd0,  5'd18, 1'b0, 5'd0, 32'h0,        1'b1, 0};
        vecs[13] = '{OP_SWAP,  5'd22, 5'd0,  1'b0, 5'd0, 32'h0,        1'b1, 0};
        vecs[14] = '{OP_MOVE,  5'd23, 5'd17, 1'b0, 5'd0, 32'h0,        1'b0, 2};
        vecs[15] = '{OP_LOADC, 5'd0,  5'd23, 1'b0, 5'd0, 32'h0,        1'b1, 0};

        clear = 1'b1; req_valid = 1'b0; req_op = '0; req_src = '0; req_dst = '0;
        req2_valid = 1'b0; req2_op = '0; req2_src = '0; req2_dst = '0;
        poke_en = 1'b0; poke_idx = '0; poke_val = '0;
        c_val = 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("reset/ready",   64'(req_ready),   64'd1);
        chk("reset/busy",    64'(busy),        64'd0);
        chk("reset/done",    64'(done),        64'd0);
        chk("reset/err",     64'(err),         64'd0);
        chk("reset/bus_sel", 64'(bus_out_sel), 64'd0);
        chk("reset/reg_sel", 64'(reg_in_sel),  64'd0);
        chk("reset/ready2",  64'(req2_ready),  64'd1);
        mon_en = 1'b1;

        for (int i = 0; i < 24; i++) begin
            if (is_tgt(i)) poke(i, $urandom);
        end

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].pre_en) poke(int'(vecs[i].pre_idx), vecs[i].pre_val);
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].src, vecs[i].dst);
            check_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].src, vecs[i].dst,
                      vecs[i].exp_err, vecs[i].exp_lat);
            if (i == 2) begin
                chk("swap_example/R0",  64'(rf[0]),  64'h12345678);
                chk("swap_example/R1",  64'(rf[1]),  64'hDEADBEEF);
                chk("swap_example/R15", 64'(rf[15]), 64'hDEADBEEF);
            end
        end

        // Clear during the second SWAP step: earlier loads stay, no done.
        old2 = rf_exp[2]; old3 = rf_exp[3];
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SWAP; req_src = 5'd2; req_dst = 5'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("clear/step2_reg_sel", 64'(reg_in_sel), 64'(24'(1) << 2));
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("clear/bus_sel", 64'(bus_out_sel), 64'd0);
        chk("clear/reg_sel", 64'(reg_in_sel),  64'd0);
        chk("clear/done",    64'(done),        64'd0);
        chk("clear/ready",   64'(req_ready),   64'd1);
        nd = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || reg_in_sel != 0) nd++;
        end
        chk("clear/quiet_after", 64'(nd), 64'd0);
        rf_exp[SCR] = old2;
        rf_exp[2]   = old3;
        check_rf("clear");

        // SETTLE_CYCLES=2 timing with a request accepted on the done cycle.
        @(negedge clk);
        req2_valid = 1'b1; req2_op = OP_MOVE; req2_src = 5'd3; req2_dst = 5'd4;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("settle_a/c%0d/bus", c),   64'(bus_out_sel2), (c <= 3) ? 64'(24'(1) << 3) : 64'd0);
            chk($sformatf("settle_a/c%0d/reg", c),   64'(reg_in_sel2),  (c == 3) ? 64'(24'(1) << 4) : 64'd0);
            chk($sformatf("settle_a/c%0d/done", c),  64'(done2),        (c == 4) ? 64'd1 : 64'd0);
            chk($sformatf("settle_a/c%0d/ready", c), 64'(req2_ready),   (c == 4) ? 64'd1 : 64'd0);
            if (c == 4) begin req2_src = 5'd5; req2_dst = 5'd6; end
        end
        @(posedge clk);
        #1 req2_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("settle_b/c%0d/bus", c),  64'(bus_out_sel2), (c <= 3) ? 64'(24'(1) << 5) : 64'd0);
            chk($sformatf("settle_b/c%0d/reg", c),  64'(reg_in_sel2),  (c == 3) ? 64'(24'(1) << 6) : 64'd0);
            chk($sformatf("settle_b/c%0d/done", c), 64'(done2),        (c == 4) ? 64'd1 : 64'd0);
        end
        chk("settle/err2", 64'(err2), 64'd0);

        // Randomized requests against the model.
        for (int n = 0; n < 40; n++) begin
            rop  = int'($urandom_range(0, 3));
            rsrc = (rop == 2) ? int'($urandom_range(0, 23)) : int'($urandom_range(0, 25));
            rdst = int'($urandom_range(0, 23));
            c_val = $urandom;
            lg = model_legal(rop, rsrc, rdst);
            run_txn($sformatf("rnd%0d", n), 2'(rop), 5'(rsrc), 5'(rdst));
            check_txn($sformatf("rnd%0d", n), 2'(rop), 5'(rsrc), 5'(rdst), ~lg,
                      lg ? ((rop == 1) ? 4 : 2) : 0);
        end

        chk("select_invariant_violations", 64'(viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
